spi_ram_slave: RTL and testbench

- Serial SPI slave front-end for a single-port RAM.
- Deserialises 10-bit MOSI words (2-bit opcode plus 8-bit payload) and presents each to the RAM with a one-cycle rx_valid strobe.
- For read-data transactions, serialises the RAM's 8-bit tx_data back out on MISO.
- Sits between the external SPI master pins and the RAM's din/rx_valid/dout/tx_valid interface.

---
 rtl/spi_ram_slave.sv | 148 ++++++++++++++
 tb/tb_spi_ram_slave.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_slave.sv
// spi_ram_slave: SPI slave front-end for a single-port RAM.
// Takes one command bit and then a 10-bit word (opcode[9:8] + payload[7:0])
// on MOSI, and hands each word to the RAM as rx_data with a one-cycle
// rx_valid strobe. In read-data frames it then waits for tx_valid and sends
// tx_data out on MISO, MSB first. MOSI is sampled once per clk, rising edge.
//
// Handshake: rx_valid is a one-cycle push with no backpressure; rx_data is
// only meaningful in that cycle and holds until the next completed word.
// tx_valid is consumed on the first clk edge that sees it high while a
// read-data frame waits for RAM data; at any other time it is ignored.
//
// Optional build: define SPI_FRAME_ERR_EN to add the frame_err output.
// frame_err pulses for one cycle when SS_n rises before a word completes
// or while MISO is still shifting.
//
// state_dbg and rd_addr_seen_dbg expose the FSM state and the read-address
// flag for observation only.
`timescale 1ns/1ps

module spi_ram_slave #(
  parameter int RX_W = 10,
  parameter int TX_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            SS_n,
  input  logic            MOSI,
  output logic            MISO,
  output logic [RX_W-1:0] rx_data,
  output logic            rx_valid,
  input  logic [TX_W-1:0] tx_data,
  input  logic            tx_valid,
`ifdef SPI_FRAME_ERR_EN
  output logic            frame_err,
`endif
  output logic [2:0]      state_dbg,
  output logic            rd_addr_seen_dbg
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CHK_CMD   = 3'd1;
  localparam logic [2:0] WRITE     = 3'd2;
  localparam logic [2:0] READ_ADD  = 3'd3;
  localparam logic [2:0] READ_DATA = 3'd4;

  localparam int RCW = $clog2(RX_W + 1);
  localparam int TCW = $clog2(TX_W + 1);

  localparam logic [RCW-1:0] RX_LAST = RCW'(RX_W - 1);
  localparam logic [RCW-1:0] RX_FULL = RCW'(RX_W);
  localparam logic [TCW-1:0] TX_FULL = TCW'(TX_W);

  logic [2:0]      state;
  logic [RCW-1:0]  rx_cnt;       // data bits taken in this frame; RX_FULL = word done
  logic [RX_W-2:0] shift_reg;    // first RX_W-1 bits of the word; the last bit comes straight from MOSI
  logic [TCW-1:0]  tx_cnt;       // MISO bits already driven in the current read-data reply
  logic [TX_W-1:0] tx_shift;     // bits still to go out on MISO, next one in the MSB
  logic            tx_active;    // MISO reply in progress
  logic            tx_done;      // reply finished for this frame; ignore tx_valid until SS_n rises
  logic            rd_addr_seen; // read address taken; next read command is a data read

  // FSM, receive shifter and MISO serialiser
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      MISO         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_cnt       <= '0;
      shift_reg    <= '0;
      tx_cnt       <= '0;
      tx_shift     <= '0;
      tx_active    <= 1'b0;
      tx_done      <= 1'b0;
      rd_addr_seen <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n) begin
        // A deselected slave always returns to IDLE. rd_addr_seen is kept so
        // that a cut-short data read can be retried.
        state     <= IDLE;
        MISO      <= 1'b0;
        rx_cnt    <= '0;
        tx_cnt    <= '0;
        tx_active <= 1'b0;
        tx_done   <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= CHK_CMD;
          CHK_CMD: begin
            if (!MOSI)             state <= WRITE;
            else if (rd_addr_seen) state <= READ_DATA;
            else                   state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (rx_cnt != RX_FULL) begin
              shift_reg <= {shift_reg[RX_W-3:0], MOSI};
              rx_cnt    <= rx_cnt + 1'b1;
              if (rx_cnt == RX_LAST) begin
                rx_data  <= {shift_reg, MOSI};
                rx_valid <= 1'b1;
                if (state == READ_ADD) rd_addr_seen <= 1'b1;
              end
            end else if (state == READ_DATA) begin
              if (tx_active) begin
                if (tx_cnt == TX_FULL) begin
                  // Last bit has gone out: the read is complete.
                  MISO         <= 1'b0;
                  tx_active    <= 1'b0;
                  tx_done      <= 1'b1;
                  rd_addr_seen <= 1'b0;
                end else begin
                  MISO     <= tx_shift[TX_W-1];
                  tx_shift <= {tx_shift[TX_W-2:0], 1'b0};
                  tx_cnt   <= tx_cnt + 1'b1;
                end
              end else if (!tx_done && tx_valid) begin
                // Drive the MSB now and keep the rest for the next edges.
                MISO      <= tx_data[TX_W-1];
                tx_shift  <= {tx_data[TX_W-2:0], 1'b0};
                tx_cnt    <= TCW'(1);
                tx_active <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SPI_FRAME_ERR_EN
  // One-cycle flag when SS_n rises with a word still incomplete or a reply still shifting
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= SS_n &&
                   (((state == WRITE || state == READ_ADD || state == READ_DATA) &&
                     rx_cnt != RX_FULL) || tx_active);
    end
  end
`endif

  assign state_dbg        = state;
  assign rd_addr_seen_dbg = rd_addr_seen;

endmodule

// File: tb/tb_spi_ram_slave.sv
// tb_spi_ram_slave: directed test for spi_ram_slave with hand-computed
// expected values. Inputs change 1 ns after each rising edge, and outputs
// are sampled at that same point.
`timescale 1ns/1ps

module tb_spi_ram_slave;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CHK_CMD   = 3'd1;
  localparam logic [2:0] S_WRITE     = 3'd2;
  localparam logic [2:0] S_READ_ADD  = 3'd3;
  localparam logic [2:0] S_READ_DATA = 3'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [2:0] state_dbg;
  logic       rd_addr_seen_dbg;
`ifdef SPI_FRAME_ERR_EN
  logic       frame_err;
`endif

  int total = 0;
  int bad   = 0;

  spi_ram_slave #(.RX_W(10), .TX_W(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .SS_n             (SS_n),
    .MOSI             (MOSI),
    .MISO             (MISO),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
`ifdef SPI_FRAME_ERR_EN
    .frame_err        (frame_err),
`endif
    .state_dbg        (state_dbg),
    .rd_addr_seen_dbg (rd_addr_seen_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: select the slave, send the command bit, check the chosen state
  task automatic start_frame(input logic cmd, input logic [2:0] exp_state, input string tag);
    SS_n = 1'b0;
    tick();
    chk({tag, "_chk_state"}, 32'(state_dbg), 32'(S_CHK_CMD));
    MOSI = cmd;
    tick();
    chk({tag, "_cmd_state"}, 32'(state_dbg), 32'(exp_state));
  endtask

  // driver: shift a 10-bit word MSB first; rx_valid only after the last bit
  task automatic shift_word(input logic [9:0] word, input logic [9:0] prev_rx, input string tag);
    for (int i = 9; i >= 0; i--) begin
      MOSI = word[i];
      tick();
      chk({tag, "_miso_idle"}, 32'(MISO), 32'd0);
      if (i > 0) begin
        chk({tag, "_no_valid"}, 32'(rx_valid), 32'd0);
        chk({tag, "_rx_hold"}, 32'(rx_data), 32'(prev_rx));
      end
    end
    chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
    chk({tag, "_rx_data"}, 32'(rx_data), 32'(word));
  endtask

  task automatic end_frame(input string tag);
    SS_n = 1'b1;
    MOSI = 1'b0;
    tick();
    chk({tag, "_end_idle"}, 32'(state_dbg), 32'(S_IDLE));
    chk({tag, "_end_miso"}, 32'(MISO), 32'd0);
    chk({tag, "_end_valid"}, 32'(rx_valid), 32'd0);
  endtask

  logic [7:0] pat;

  initial begin
    rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    tick();
    tick();
    chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
    chk("rst_miso", 32'(MISO), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rd_seen", 32'(rd_addr_seen_dbg), 32'd0);
`ifdef SPI_FRAME_ERR_EN
    chk("rst_frame_err", 32'(frame_err), 32'd0);
`endif
    rst = 1'b0;
    tick();
    chk("idle_hold", 32'(state_dbg), 32'(S_IDLE));

    // write address
    start_frame(1'b0, S_WRITE, "wr_addr");
    shift_word(10'h004, 10'h000, "wr_addr");
    tick();
    chk("wr_addr_pulse_once", 32'(rx_valid), 32'd0);
    end_frame("wr_addr");
    chk("wr_addr_rd_seen", 32'(rd_addr_seen_dbg), 32'd0);

    // write data, then extra MOSI bits and a stray tx_valid that must be ignored
    start_frame(1'b0, S_WRITE, "wr_data");
    shift_word(10'h10F, 10'h004, "wr_data");
    tx_data = 8'hFF; tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      MOSI = 1'b1;
      tick();
      chk("wr_extra_no_valid", 32'(rx_valid), 32'd0);
      chk("wr_extra_rx_hold", 32'(rx_data), 32'h10F);
      chk("wr_extra_miso", 32'(MISO), 32'd0);
    end
    tx_valid = 1'b0;
    end_frame("wr_data");
    chk("wr_data_rd_seen", 32'(rd_addr_seen_dbg), 32'd0);

    // read address
    start_frame(1'b1, S_READ_ADD, "rd_addr");
    shift_word(10'h204, 10'h10F, "rd_addr");
    chk("rd_addr_seen_set", 32'(rd_addr_seen_dbg), 32'd1);
    end_frame("rd_addr");
    chk("rd_addr_seen_kept", 32'(rd_addr_seen_dbg), 32'd1);

    // read data, reply 0xAA
    start_frame(1'b1, S_READ_DATA, "rd_data");
    shift_word(10'h300, 10'h204, "rd_data");
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rd_wait_miso", 32'(MISO), 32'd0);
    end
    tx_data = 8'hAA; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("rd_bit7", 32'(MISO), 32'd1);
    pat = 8'b0101_0100;  // expected bits 6..0 of 0xAA, MSB first
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("rd_bit", 32'(MISO), 32'(pat[7]));
      pat = {pat[6:0], 1'b0};
    end
    tick();
    chk("rd_after_miso", 32'(MISO), 32'd0);
    chk("rd_seen_cleared", 32'(rd_addr_seen_dbg), 32'd0);
    tx_data = 8'hFF; tx_valid = 1'b1;
    tick();
    chk("rd_tx_ignored", 32'(MISO), 32'd0);
    tx_valid = 1'b0;
    end_frame("rd_data");

    // the next read command goes back to READ_ADD
    start_frame(1'b1, S_READ_ADD, "rd_addr2");
    shift_word(10'h2A5, 10'h300, "rd_addr2");
    end_frame("rd_addr2");
    chk("rd_addr2_seen", 32'(rd_addr_seen_dbg), 32'd1);

    // abort a write after 5 data bits
    start_frame(1'b0, S_WRITE, "abort");
    for (int i = 0; i < 5; i++) begin
      MOSI = i[0];
      tick();
    end
    SS_n = 1'b1;
    tick();
    chk("abort_idle", 32'(state_dbg), 32'(S_IDLE));
    chk("abort_no_valid", 32'(rx_valid), 32'd0);
    chk("abort_rx_hold", 32'(rx_data), 32'h2A5);
    chk("abort_rd_seen", 32'(rd_addr_seen_dbg), 32'd1);
`ifdef SPI_FRAME_ERR_EN
    chk("abort_frame_err", 32'(frame_err), 32'd1);
    tick();
    chk("abort_frame_err_once", 32'(frame_err), 32'd0);
`endif

    // read data aborted while MISO shifts 0x96
    start_frame(1'b1, S_READ_DATA, "rd_abort");
    shift_word(10'h3C3, 10'h2A5, "rd_abort");
    tx_data = 8'h96; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("rd_abort_bit7", 32'(MISO), 32'd1);
    tick();
    chk("rd_abort_bit6", 32'(MISO), 32'd0);
    tick();
    chk("rd_abort_bit5", 32'(MISO), 32'd0);
    tick();
    chk("rd_abort_bit4", 32'(MISO), 32'd1);
    SS_n = 1'b1;
    tick();
    chk("rd_abort_miso", 32'(MISO), 32'd0);
    chk("rd_abort_idle", 32'(state_dbg), 32'(S_IDLE));
    chk("rd_abort_seen", 32'(rd_addr_seen_dbg), 32'd1);
`ifdef SPI_FRAME_ERR_EN
    chk("rd_abort_frame_err", 32'(frame_err), 32'd1);
`endif

    // retry re-enters READ_DATA, then reset in the middle of the reply
    start_frame(1'b1, S_READ_DATA, "retry");
    shift_word(10'h3FF, 10'h3C3, "retry");
    tx_data = 8'hFF; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("retry_bit7", 32'(MISO), 32'd1);
    tick();
    chk("retry_bit6", 32'(MISO), 32'd1);
    rst = 1'b1;
    tick();
    chk("midrst_miso", 32'(MISO), 32'd0);
    chk("midrst_valid", 32'(rx_valid), 32'd0);
    chk("midrst_rx_data", 32'(rx_data), 32'd0);
    chk("midrst_state", 32'(state_dbg), 32'(S_IDLE));
    chk("midrst_rd_seen", 32'(rd_addr_seen_dbg), 32'd0);
    rst = 1'b0;
    SS_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(state_dbg), 32'(S_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
